// File: rtl/uart_rx_if.sv
// Serial receive bus: the raw line in, plus the received byte and its status pulses out.
// The receiver uses the master modport; whatever drives the line and consumes bytes uses slave.
interface uart_rx_if;
  logic       i_Rx;
  logic [7:0] o_data;
  logic       o_DV;
  logic       o_frame_err;
  logic       o_busy;

  modport master (input i_Rx, output o_data, output o_DV, output o_frame_err, output o_busy);
  modport slave  (output i_Rx, input o_data, input o_DV, input o_frame_err, input o_busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, sampling each bit at its centre using a single bit-timing counter.
// Emits one-cycle o_DV for a good byte, or one-cycle o_frame_err for a bad stop bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic   clk,
  input  logic   i_nRST,
  uart_rx_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx: CLKS_PER_BIT=%0d is unsupported, must be at least 4", CLKS_PER_BIT);
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    shift, shift_d;
  logic [7:0]    data, data_d;
  logic          dv, dv_d;
  logic          ferr, ferr_d;
  logic          rx_m, rx_s;

  // Flops reset to 1 so the idle-high line never looks like a start edge after reset.
  always_ff @(posedge clk or negedge i_nRST) begin
    if (!i_nRST) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.i_Rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge i_nRST) begin
    if (!i_nRST) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      data  <= '0;
      dv    <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      shift <= shift_d;
      data  <= data_d;
      dv    <= dv_d;
      ferr  <= ferr_d;
    end
  end

  // The stop bit is judged at its centre and the FSM drops straight back to IDLE,
  // so a start edge in the second half of the stop bit is still caught.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shift_d = shift;
    data_d  = data;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_d        = '0;
          shift_d[idx] = rx_s;
          if (idx == 3'd7) state_d = STOP;
          else             idx_d   = idx + 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift;
            dv_d    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign bus.o_data      = data;
  assign bus.o_DV        = dv;
  assign bus.o_frame_err = ferr;
  assign bus.o_busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a CLKS_PER_BIT=16 instance for most scenarios and a
// default-parameter instance fed by a 2% slow transmitter.
module tb_uart_rx;

  localparam int CPB      = 16;
  localparam int CPB_DEF  = 1250;
  localparam int SLOW_BIT = 1275;
  localparam int LAT_MIN  = 2 + 1 + (CPB - 1) / 2 + 9 * CPB - 1;
  localparam int LAT_MAX  = 2 + 1 + (CPB - 1) / 2 + 9 * CPB + 1;

  logic clk;
  logic rst_n;
  logic rx16;
  logic rxd;

  uart_rx_if bus16 ();
  uart_rx_if bus_d ();

  assign bus16.i_Rx = rx16;
  assign bus_d.i_Rx = rxd;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .i_nRST (rst_n),
    .bus    (bus16)
  );

  uart_rx dut_def (
    .clk    (clk),
    .i_nRST (rst_n),
    .bus    (bus_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int         fall_q[$];
  int         dv_cyc[$];
  logic [7:0] dv_data[$];
  int         fe_cnt      = 0;
  int         both_cnt    = 0;
  int         data_glitch = 0;
  logic [7:0] prev_data   = 8'h00;

  logic [7:0] dvd_data[$];
  int         fed_cnt       = 0;
  logic [7:0] exp_data      = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every pulse on the negative edge, away from where outputs change.
  always @(negedge clk) begin
    if (bus16.o_DV === 1'b1) begin
      dv_data.push_back(bus16.o_data);
      dv_cyc.push_back(cyc);
    end
    if (bus16.o_frame_err === 1'b1) fe_cnt++;
    if (bus16.o_DV === 1'b1 && bus16.o_frame_err === 1'b1) both_cnt++;
    if (rst_n === 1'b1 && bus16.o_data !== prev_data && bus16.o_DV !== 1'b1) data_glitch++;
    prev_data = bus16.o_data;
    if (bus_d.o_DV === 1'b1) dvd_data.push_back(bus_d.o_data);
    if (bus_d.o_frame_err === 1'b1) fed_cnt++;
  end

  task automatic idle16(input int n);
    rx16 = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    fall_q.push_back(cyc);
    rx16 = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx16 = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx16 = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx16  = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus16.o_data !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_data: got %h expected 00", bus16.o_data);
    end
    n_checks++;
    if (bus16.o_DV !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_dv: got %b expected 0", bus16.o_DV);
    end
    n_checks++;
    if (bus16.o_frame_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ferr: got %b expected 0", bus16.o_frame_err);
    end
    n_checks++;
    if (bus16.o_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_busy: got %b expected 0", bus16.o_busy);
    end
    rst_n = 1'b1;
    idle16(10);
    n_checks++;
    if (bus16.o_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_busy: got %b expected 0", bus16.o_busy);
    end
  endtask

  task automatic test_single;
    int base  = dv_data.size();
    int fbase = fall_q.size();
    int fe0   = fe_cnt;
    logic busy_mid;
    fork
      send_frame(8'h44, 1'b1);
      begin
        repeat (40) @(negedge clk);
        busy_mid = bus16.o_busy;
      end
    join
    idle16(20);
    n_checks++;
    if (busy_mid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_busy_mid: got %b expected 1", busy_mid);
    end
    n_checks++;
    if (dv_data.size() - base != 1) begin
      n_fail++;
      $display("[TB] FAIL single_dv_count: got %0d expected 1", dv_data.size() - base);
    end else begin
      n_checks++;
      if (dv_data[base] !== 8'h44) begin
        n_fail++;
        $display("[TB] FAIL single_data: got %h expected 44", dv_data[base]);
      end
      n_checks++;
      if (dv_cyc[base] - fall_q[fbase] < LAT_MIN || dv_cyc[base] - fall_q[fbase] > LAT_MAX) begin
        n_fail++;
        $display("[TB] FAIL single_latency: got %0d expected %0d..%0d",
                 dv_cyc[base] - fall_q[fbase], LAT_MIN, LAT_MAX);
      end
    end
    n_checks++;
    if (fe_cnt != fe0) begin
      n_fail++;
      $display("[TB] FAIL single_ferr: got %0d pulses expected 0", fe_cnt - fe0);
    end
    n_checks++;
    if (bus16.o_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_busy_after: got %b expected 0", bus16.o_busy);
    end
    exp_data = 8'h44;
  endtask

  task automatic test_frame_error;
    int base = dv_data.size();
    int fe0  = fe_cnt;
    send_frame(8'h4F, 1'b0);
    rx16 = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    n_checks++;
    if (bus16.o_busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL break_busy: got %b expected 1", bus16.o_busy);
    end
    idle16(2 * CPB);
    n_checks++;
    if (fe_cnt - fe0 != 1) begin
      n_fail++;
      $display("[TB] FAIL break_ferr_count: got %0d expected 1", fe_cnt - fe0);
    end
    n_checks++;
    if (dv_data.size() != base) begin
      n_fail++;
      $display("[TB] FAIL break_dv_count: got %0d expected 0", dv_data.size() - base);
    end
    n_checks++;
    if (bus16.o_data !== exp_data) begin
      n_fail++;
      $display("[TB] FAIL break_data_hold: got %h expected %h", bus16.o_data, exp_data);
    end
    n_checks++;
    if (bus16.o_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL break_recover_busy: got %b expected 0", bus16.o_busy);
    end
    send_frame(8'h4D, 1'b1);
    idle16(20);
    n_checks++;
    if (dv_data.size() - base != 1) begin
      n_fail++;
      $display("[TB] FAIL after_break_dv_count: got %0d expected 1", dv_data.size() - base);
    end else begin
      n_checks++;
      if (dv_data[base] !== 8'h4D) begin
        n_fail++;
        $display("[TB] FAIL after_break_data: got %h expected 4d", dv_data[base]);
      end
    end
    exp_data = 8'h4D;
  endtask

  task automatic test_glitch;
    int base = dv_data.size();
    int fe0  = fe_cnt;
    rx16 = 1'b0;
    repeat (5) @(negedge clk);
    idle16(40);
    n_checks++;
    if (dv_data.size() != base || fe_cnt != fe0) begin
      n_fail++;
      $display("[TB] FAIL glitch_pulses: got dv=%0d ferr=%0d expected 0 and 0",
               dv_data.size() - base, fe_cnt - fe0);
    end
    n_checks++;
    if (bus16.o_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL glitch_idle: got busy=%b expected 0", bus16.o_busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] msg [4] = '{8'h69, 8'h44, 8'h4F, 8'h4D};
    int base  = dv_data.size();
    int fbase = fall_q.size();
    int fe0   = fe_cnt;
    for (int i = 0; i < 4; i++) send_frame(msg[i], 1'b1);
    idle16(20);
    n_checks++;
    if (dv_data.size() - base != 4) begin
      n_fail++;
      $display("[TB] FAIL b2b_dv_count: got %0d expected 4", dv_data.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (dv_data[base + i] !== msg[i]) begin
          n_fail++;
          $display("[TB] FAIL b2b_data%0d: got %h expected %h", i, dv_data[base + i], msg[i]);
        end
        n_checks++;
        if (dv_cyc[base + i] - fall_q[fbase + i] < LAT_MIN ||
            dv_cyc[base + i] - fall_q[fbase + i] > LAT_MAX) begin
          n_fail++;
          $display("[TB] FAIL b2b_latency%0d: got %0d expected %0d..%0d", i,
                   dv_cyc[base + i] - fall_q[fbase + i], LAT_MIN, LAT_MAX);
        end
      end
    end
    n_checks++;
    if (fe_cnt != fe0) begin
      n_fail++;
      $display("[TB] FAIL b2b_ferr: got %0d pulses expected 0", fe_cnt - fe0);
    end
    exp_data = 8'h4D;
  endtask

  task automatic test_reset_mid_frame;
    int base = dv_data.size();
    int fe0  = fe_cnt;
    logic [7:0] b = 8'h44;
    rx16 = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx16 = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx16 = b[3];
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus16.o_data !== 8'h00 || bus16.o_DV !== 1'b0 ||
        bus16.o_frame_err !== 1'b0 || bus16.o_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midreset_outputs: got data=%h dv=%b ferr=%b busy=%b expected 00 0 0 0",
               bus16.o_data, bus16.o_DV, bus16.o_frame_err, bus16.o_busy);
    end
    repeat (3) @(negedge clk);
    rx16  = 1'b1;
    rst_n = 1'b1;
    idle16(10 * CPB);
    n_checks++;
    if (dv_data.size() != base || fe_cnt != fe0) begin
      n_fail++;
      $display("[TB] FAIL midreset_pulses: got dv=%0d ferr=%0d expected 0 and 0",
               dv_data.size() - base, fe_cnt - fe0);
    end
    send_frame(8'h69, 1'b1);
    idle16(20);
    n_checks++;
    if (dv_data.size() - base != 1) begin
      n_fail++;
      $display("[TB] FAIL midreset_next_count: got %0d expected 1", dv_data.size() - base);
    end else begin
      n_checks++;
      if (dv_data[base] !== 8'h69) begin
        n_fail++;
        $display("[TB] FAIL midreset_next_data: got %h expected 69", dv_data[base]);
      end
    end
    n_checks++;
    if (both_cnt != 0 || data_glitch != 0) begin
      n_fail++;
      $display("[TB] FAIL pulse_rules: got overlap=%0d stray_data_changes=%0d expected 0 and 0",
               both_cnt, data_glitch);
    end
  endtask

  task automatic test_slow_baud;
    logic [7:0] b = 8'h4D;
    int base = dvd_data.size();
    int fe0  = fed_cnt;
    rxd = 1'b0;
    repeat (SLOW_BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (SLOW_BIT) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (SLOW_BIT + 100) @(negedge clk);
    n_checks++;
    if (dvd_data.size() - base != 1) begin
      n_fail++;
      $display("[TB] FAIL slow_dv_count: got %0d expected 1", dvd_data.size() - base);
    end else begin
      n_checks++;
      if (dvd_data[base] !== 8'h4D) begin
        n_fail++;
        $display("[TB] FAIL slow_data: got %h expected 4d", dvd_data[base]);
      end
    end
    n_checks++;
    if (fed_cnt != fe0) begin
      n_fail++;
      $display("[TB] FAIL slow_ferr: got %0d pulses expected 0", fed_cnt - fe0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rx16  = 1'b1;
    rxd   = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_frame_error();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_slow_baud();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 1250, clk cycles per bit period (12 MHz / 9600 baud).
REQ-002 SHALL have port: clk  input  1  system clock, 12 MHz, all logic on rising edge.
REQ-003 SHALL have port: i_nRST  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: i_Rx  input  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-005 SHALL have port: o_data  output  8  last correctly framed received byte.
REQ-006 SHALL have port: o_DV  output  1  data-valid pulse, high exactly one cycle per good byte.
REQ-007 SHALL have port: o_frame_err  output  1  framing-error pulse, high exactly one cycle per bad stop bit.
REQ-008 SHALL have port: o_busy  output  1  high in every state except IDLE.

Function
REQ-009 SHALL pass i_Rx through a 2-flop synchronizer with both flops reset to 1; all decisions use the synchronized bit rx_s.
REQ-010 SHALL use one bit-timing counter of width $clog2(CLKS_PER_BIT), and a 3-bit bit index.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH, with no other reachable state; illegal encodings SHALL go to IDLE.
REQ-012 IDLE: counter held 0; rx_s==0 -> START next cycle.
REQ-013 START: count to (CLKS_PER_BIT-1)/2 (mid start bit); there rx_s==0 -> DATA with counter and index cleared; rx_s==1 -> IDLE as a glitch, with no output pulse.
REQ-014 DATA: count 0..CLKS_PER_BIT-1; at terminal count shift rx_s into bit[index] (LSB first), clear counter; index 7 -> STOP, else index+1.
REQ-015 STOP: at terminal count sample rx_s; 1 -> load o_data with shift register, o_DV=1 next cycle, -> IDLE; 0 -> o_frame_err=1 next cycle, o_data unchanged, -> WAIT_HIGH.
REQ-016 WAIT_HIGH: remain until rx_s==1, then -> IDLE, so that a held-low line (break) yields exactly one o_frame_err.
REQ-017 Return to IDLE at mid stop bit SHALL allow a start edge arriving in the second half of the stop bit to be accepted, so back-to-back frames need no idle gap.
REQ-018 Latency: o_DV asserts 2 (sync) + 1 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT cycles after i_Rx falls, ±1 cycle.
REQ-019 o_DV and o_frame_err SHALL never be high in the same cycle; both are registered outputs.
REQ-020 o_data SHALL change only in the cycle o_DV rises, and SHALL hold its value otherwise.
REQ-021 CLKS_PER_BIT < 4 is unsupported; a simulation-time check SHALL report an error.

Reset
REQ-022 i_nRST low SHALL asynchronously force: state IDLE, counter 0, index 0, shift register 0x00, o_data 0x00, o_DV 0, o_frame_err 0, o_busy 0, synchronizer flops 1.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no pulse; after release, reception SHALL start only from the next falling edge seen in IDLE.

Verification (bench uses CLKS_PER_BIT=16 unless stated)
REQ-024 Single frame 0x44 ("D"), stop=1 -> o_DV one cycle, o_data=0x44, o_frame_err stays 0, o_busy high from start detect to the pulse.
REQ-025 Back-to-back frames 0x69,0x44,0x4F,0x4D ("iDOM"), no idle gap -> four o_DV pulses with o_data 0x69,0x44,0x4F,0x4D in order, and latency per REQ-018 on each.
REQ-026 i_Rx low for 5 cycles, then high -> no o_DV, no o_frame_err, state back to IDLE.
REQ-027 Frame 0x4F with stop bit 0, then line held low 40 bit times -> exactly one o_frame_err, o_DV 0, o_data keeps prior value; after line returns high, frame 0x4D is received correctly.
REQ-028 i_nRST pulsed low during bit 3 of a 0x44 frame -> all outputs 0 immediately, no pulse for the partial frame; next 0x69 frame -> o_data=0x69 with o_DV.
REQ-029 Default CLKS_PER_BIT=1250, frame 0x4D sent with a bit period 2% slow -> o_data=0x4D with o_DV, no error.
